// File: rtl/exu_alu_sched_pkg.sv
// Shared widths, slot indices and packed types for the ALU issue scheduler.
`ifndef EXU_ALU_SCHED_DEFINES
`define EXU_ALU_SCHED_DEFINES
`define XLEN            32
`define RFIDXLEN        5
`define DECINFO_GRPLEN  3
`define DECINFOLEN      16
`define ALU_SCHED_DEPTH 2
`define WB_ENTRY_LEN    (`RFIDXLEN + `XLEN)
`endif

package exu_alu_sched_pkg;

    localparam int XLEN            = `XLEN;
    localparam int RFIDXLEN        = `RFIDXLEN;
    localparam int GRPLEN          = `DECINFO_GRPLEN;
    localparam int INFOLEN         = `DECINFOLEN;
    localparam int ALU_SCHED_DEPTH = `ALU_SCHED_DEPTH;
    localparam int WB_ENTRY_LEN    = `WB_ENTRY_LEN;

    // Issue slot indices; also the value rr holds when that slot has priority.
    localparam int IS0 = 0;
    localparam int IS1 = 1;

    // One writeback FIFO entry.
    typedef struct packed {
        logic [RFIDXLEN-1:0] rdidx;
        logic [XLEN-1:0]     data;
    } wb_entry_t;

    // Everything a slot hands to the ALU.
    typedef struct packed {
        logic [RFIDXLEN-1:0] rdidx;
        logic [GRPLEN-1:0]   grp;
        logic [INFOLEN-1:0]  info;
        logic [XLEN-1:0]     op1;
        logic [XLEN-1:0]     op2;
    } alu_req_t;

endpackage

// File: rtl/exu_wb_fifo.sv
// Generic valid/ready FIFO with count, full and synchronous flush.
module exu_wb_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 37,
    localparam int PTRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [CNTW-1:0]  o_count,
    output logic             o_full
);

    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] we;
    logic             do_push;
    logic             do_pop;

    // A flush wins over both push and pop; a push into a full FIFO is dropped.
    assign do_push = i_push && !o_full && !i_flush;
    assign do_pop  = o_valid && i_ready && !i_flush;

    // Per-entry write enables decoded from the write pointer.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
        assign we[gi] = do_push && (wr_ptr_q == PTRW'(gi));
    end

    // Pointer and occupancy next-state; pointers wrap since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTRW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
            count_d = count_q + CNTW'(do_push) - CNTW'(do_pop);
        end
    end

    // Control state register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until counted as valid.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we[i]) mem_q[i] <= i_push_data;
        end
    end

    assign o_valid = (count_q != '0);
    assign o_full  = (count_q == CNTW'(DEPTH));
    assign o_count = count_q;
    assign o_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/exu_alu_sched.sv
// Round-robin sharing of one ALU between two issue slots, with a writeback FIFO.
module exu_alu_sched
    import exu_alu_sched_pkg::*;
#(
    parameter int WB_DEPTH = ALU_SCHED_DEPTH
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_flush,
    input  logic                i_is0_valid,
    output logic                o_is0_ready,
    input  logic [RFIDXLEN-1:0] i_is0_rdidx,
    input  logic [GRPLEN-1:0]   i_is0_grp,
    input  logic [INFOLEN-1:0]  i_is0_info,
    input  logic [XLEN-1:0]     i_is0_op1,
    input  logic [XLEN-1:0]     i_is0_op2,
    input  logic                i_is1_valid,
    output logic                o_is1_ready,
    input  logic [RFIDXLEN-1:0] i_is1_rdidx,
    input  logic [GRPLEN-1:0]   i_is1_grp,
    input  logic [INFOLEN-1:0]  i_is1_info,
    input  logic [XLEN-1:0]     i_is1_op1,
    input  logic [XLEN-1:0]     i_is1_op2,
    output logic [RFIDXLEN-1:0] o_alu_rdidx,
    output logic [GRPLEN-1:0]   o_alu_grp,
    output logic [INFOLEN-1:0]  o_alu_info,
    output logic [XLEN-1:0]     o_alu_op1,
    output logic [XLEN-1:0]     o_alu_op2,
    input  logic                i_alu_rdwen,
    input  logic [RFIDXLEN-1:0] i_alu_rdidx,
    input  logic [XLEN-1:0]     i_alu_rdwdata,
    output logic                o_wb_valid,
    input  logic                i_wb_ready,
    output logic [RFIDXLEN-1:0] o_wb_rdidx,
    output logic [XLEN-1:0]     o_wb_rdwdata,
    output logic                o_busy
);

    localparam int CNTW = $clog2(WB_DEPTH + 1);

    logic            rr_q, rr_d;
    logic            can_issue;
    logic            grant0, grant1;
    logic            push;
    logic            fifo_full;
    logic [CNTW-1:0] fifo_count;
    alu_req_t        req0, req1, req_sel;
    wb_entry_t       push_entry, head_entry;

    assign req0 = {i_is0_rdidx, i_is0_grp, i_is0_info, i_is0_op1, i_is0_op2};
    assign req1 = {i_is1_rdidx, i_is1_grp, i_is1_info, i_is1_op1, i_is1_op2};

    // Issue only into a free registered slot, so wb_ready never reaches the readies.
    assign can_issue = !i_flush && !fifo_full;

    // Grant: a lone valid slot wins outright, a tie goes to the rr slot.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (i_rstn && can_issue) begin
            if (i_is0_valid && !i_is1_valid) begin
                grant0 = 1'b1;
            end else if (!i_is0_valid && i_is1_valid) begin
                grant1 = 1'b1;
            end else if (i_is0_valid && i_is1_valid) begin
                if (rr_q == 1'(IS0)) grant0 = 1'b1;
                else                 grant1 = 1'b1;
            end
        end
    end

    // Priority passes to the other slot after every grant; idle or flush holds it.
    always_comb begin
        rr_d = rr_q;
        if (grant0)      rr_d = 1'(IS1);
        else if (grant1) rr_d = 1'(IS0);
    end

    // Round-robin pointer register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) rr_q <= 1'(IS0);
        else         rr_q <= rr_d;
    end

    // Steer the winner onto the ALU; all-zero (grp=0) when nothing is granted.
    always_comb begin
        req_sel = '0;
        if (grant0)      req_sel = req0;
        else if (grant1) req_sel = req1;
    end

    assign o_is0_ready = grant0;
    assign o_is1_ready = grant1;
    assign o_alu_rdidx = req_sel.rdidx;
    assign o_alu_grp   = req_sel.grp;
    assign o_alu_info  = req_sel.info;
    assign o_alu_op1   = req_sel.op1;
    assign o_alu_op2   = req_sel.op2;

    // Ops that do not write a register complete without taking an entry.
    assign push       = (grant0 || grant1) && i_alu_rdwen;
    assign push_entry = '{rdidx: i_alu_rdidx, data: i_alu_rdwdata};

    exu_wb_fifo #(
        .DEPTH (WB_DEPTH),
        .WIDTH (WB_ENTRY_LEN)
    ) u_wb_fifo (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_flush     (i_flush),
        .i_push      (push),
        .i_push_data (push_entry),
        .o_valid     (o_wb_valid),
        .i_ready     (i_wb_ready),
        .o_data      (head_entry),
        .o_count     (fifo_count),
        .o_full      (fifo_full)
    );

    assign o_wb_rdidx   = head_entry.rdidx;
    assign o_wb_rdwdata = head_entry.data;
    assign o_busy       = (fifo_count != '0);

endmodule

// File: tb/tb_exu_alu_sched.sv
// Bench for exu_alu_sched: directed scenarios plus random traffic against a queue model.
module tb_exu_alu_sched;
    import exu_alu_sched_pkg::*;

    localparam int DEPTH = 2;
    localparam logic [15:0] INFO_ADD  = 16'h0001;
    localparam logic [15:0] INFO_NOWB = 16'h8001;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        wb_ready = 1'b0;
    logic        s_valid [2];
    logic [4:0]  s_rdidx [2];
    logic [2:0]  s_grp   [2];
    logic [15:0] s_info  [2];
    logic [31:0] s_op1   [2];
    logic [31:0] s_op2   [2];
    logic        ready0, ready1;
    logic [4:0]  alu_rdidx_o;
    logic [2:0]  alu_grp_o;
    logic [15:0] alu_info_o;
    logic [31:0] alu_op1_o, alu_op2_o;
    logic        alu_wen;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        wb_valid, busy;
    logic [4:0]  wb_rdidx;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exu_alu_sched #(.WB_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_flush(flush),
        .i_is0_valid(s_valid[0]), .o_is0_ready(ready0), .i_is0_rdidx(s_rdidx[0]),
        .i_is0_grp(s_grp[0]), .i_is0_info(s_info[0]), .i_is0_op1(s_op1[0]), .i_is0_op2(s_op2[0]),
        .i_is1_valid(s_valid[1]), .o_is1_ready(ready1), .i_is1_rdidx(s_rdidx[1]),
        .i_is1_grp(s_grp[1]), .i_is1_info(s_info[1]), .i_is1_op1(s_op1[1]), .i_is1_op2(s_op2[1]),
        .o_alu_rdidx(alu_rdidx_o), .o_alu_grp(alu_grp_o), .o_alu_info(alu_info_o),
        .o_alu_op1(alu_op1_o), .o_alu_op2(alu_op2_o),
        .i_alu_rdwen(alu_wen), .i_alu_rdidx(alu_rd), .i_alu_rdwdata(alu_data),
        .o_wb_valid(wb_valid), .i_wb_ready(wb_ready), .o_wb_rdidx(wb_rdidx),
        .o_wb_rdwdata(wb_data), .o_busy(busy)
    );

    // ALU stand-in: grp=0 means nothing; info[15] = no register write; info[0] add else xor.
    function automatic logic [37:0] alu_ref(input logic [2:0] grp, input logic [15:0] info,
                                            input logic [4:0] rd, input logic [31:0] a, b);
        if (grp == 3'd0) return '0;
        return {!info[15], rd, info[0] ? a + b : a ^ b};
    endfunction

    always_comb {alu_wen, alu_rd, alu_data} = alu_ref(alu_grp_o, alu_info_o, alu_rdidx_o, alu_op1_o, alu_op2_o);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of pending results plus the priority slot.
    logic [36:0] mq[$];
    int          m_rr = 0;

    always @(negedge clk) begin
        bit can, g0, g1;
        logic [37:0] r;
        int gs;
        if (!rstn) begin
            chk("rst_ready", {ready0, ready1}, 2'b00);
            chk("rst_wb", {wb_valid, busy}, 2'b00);
            chk("rst_alu", {alu_rdidx_o, alu_grp_o, alu_info_o, alu_op1_o, alu_op2_o}, '0);
            mq.delete();
            m_rr = 0;
        end else begin
            can = !flush && (mq.size() < DEPTH);
            g0 = can && s_valid[0] && (!s_valid[1] || m_rr == 0);
            g1 = can && s_valid[1] && (!s_valid[0] || m_rr == 1);
            gs = g1 ? 1 : 0;
            chk("ready", {ready0, ready1}, {g0, g1});
            if (g0 || g1)
                chk("alu_in", {alu_rdidx_o, alu_grp_o, alu_info_o, alu_op1_o, alu_op2_o},
                    {s_rdidx[gs], s_grp[gs], s_info[gs], s_op1[gs], s_op2[gs]});
            else
                chk("alu_idle", {alu_rdidx_o, alu_grp_o, alu_info_o, alu_op1_o, alu_op2_o}, '0);
            chk("wb_valid", {wb_valid, busy}, {2{mq.size() != 0}});
            if (mq.size() != 0) chk("wb_entry", {wb_rdidx, wb_data}, mq[0]);
            if (g0 || g1)
                $display("issue slot%0d rd=%0d op1=%0h op2=%0h", gs, s_rdidx[gs], s_op1[gs], s_op2[gs]);
            if (flush) begin
                mq.delete();
            end else begin
                if (mq.size() != 0 && wb_ready) begin
                    $display("wb rd=%0d data=%0h", mq[0][36:32], mq[0][31:0]);
                    void'(mq.pop_front());
                end
                if (g0 || g1) begin
                    r = alu_ref(s_grp[gs], s_info[gs], s_rdidx[gs], s_op1[gs], s_op2[gs]);
                    if (r[37]) mq.push_back(r[36:0]);
                end
            end
            if (g0) m_rr = 1;
            else if (g1) m_rr = 0;
        end
    end

    task automatic set_slot(input int n, input logic v, input logic [4:0] rd, input logic [2:0] grp,
                            input logic [15:0] info, input logic [31:0] a, input logic [31:0] b);
        s_valid[n] = v; s_rdidx[n] = rd; s_grp[n] = grp; s_info[n] = info; s_op1[n] = a; s_op2[n] = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_valid[0] = 1'b0;
        s_valid[1] = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int ngr;
        set_slot(0, 0, 0, 0, 0, 0, 0);
        set_slot(1, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        rstn = 1'b1;
        wb_ready = 1'b1;

        // Both slots valid after reset: IS0, IS1, IS0, IS1, results in order.
        set_slot(0, 1, 5'd1, 3'd1, INFO_ADD, 32'd10, 32'd1);
        set_slot(1, 1, 5'd2, 3'd1, INFO_ADD, 32'd20, 32'd2);
        for (int k = 0; k < 5; k++) begin
            if (k == 4) idle(0);
            @(negedge clk);
            if (k < 4) chk("rr_seq", {ready0, ready1}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k > 0) chk("rr_wb", {wb_valid, wb_rdidx, wb_data},
                           ((k - 1) % 2 == 0) ? {1'b1, 5'd1, 32'd11} : {1'b1, 5'd2, 32'd22});
            tick();
        end
        idle(1);

        // Single slot add: 5 + 7 into r3, visible one cycle after the grant.
        set_slot(0, 1, 5'd3, 3'd1, INFO_ADD, 32'd5, 32'd7);
        @(negedge clk);
        chk("add_ready", {ready0, ready1}, 2'b10);
        tick();
        idle(0);
        @(negedge clk);
        chk("add_wb", {wb_valid, wb_rdidx, wb_data}, {1'b1, 5'd3, 32'd12});
        idle(2);

        // Backpressure: exactly two grants, then a grant one cycle after the first pop.
        wb_ready = 1'b0;
        set_slot(0, 1, 5'd4, 3'd1, INFO_ADD, 32'd100, 32'd1);
        set_slot(1, 1, 5'd5, 3'd2, 16'h0000, 32'hF0, 32'h0F);
        ngr = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ngr += int'(ready0 | ready1);
            tick();
        end
        chk("bp_grants", ngr, 2);
        wb_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_noissue", {ready0 | ready1, wb_valid}, 2'b01);
        tick();
        @(negedge clk);
        chk("bp_regrant", ready0 | ready1, 1'b1);
        tick();
        idle(3);

        // Non-writing op: granted, but nothing enters the FIFO.
        set_slot(0, 1, 5'd6, 3'd1, INFO_NOWB, 32'd1, 32'd2);
        @(negedge clk);
        chk("nowb_ready", ready0, 1'b1);
        tick();
        idle(0);
        @(negedge clk);
        chk("nowb_empty", {wb_valid, busy}, 2'b00);
        idle(1);

        // Flush with a full FIFO.
        wb_ready = 1'b0;
        set_slot(0, 1, 5'd7, 3'd1, INFO_ADD, 32'd3, 32'd4);
        set_slot(1, 1, 5'd8, 3'd1, INFO_ADD, 32'd30, 32'd40);
        repeat (3) tick();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_nogrant", {ready0, ready1, wb_valid}, 3'b001);
        tick();
        flush = 1'b0;
        idle(0);
        @(negedge clk);
        chk("flush_empty", {wb_valid, busy}, 2'b00);
        s_valid[0] = 1'b1;
        s_valid[1] = 1'b1;
        tick();
        wb_ready = 1'b1;
        idle(2);

        // Asynchronous reset mid-stream with one entry held.
        wb_ready = 1'b0;
        s_valid[0] = 1'b1;
        tick();
        idle(1);
        s_valid[0] = 1'b1;
        s_valid[1] = 1'b1;
        s_info[0] = INFO_ADD;
        s_grp[0] = 3'd1;
        rstn = 1'b0;
        #1;
        chk("arst_outputs", {wb_valid, busy, ready0, ready1, alu_op1_o, alu_grp_o}, '0);
        tick();
        rstn = 1'b1;
        wb_ready = 1'b1;
        @(negedge clk);
        chk("arst_first_grant", {ready0, ready1}, 2'b10);
        tick();
        idle(2);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            for (int n = 0; n < 2; n++)
                set_slot(n, 1'($urandom_range(0, 3) != 0), 5'($urandom), 3'($urandom_range(0, 7)),
                         16'($urandom), $urandom, $urandom);
            wb_ready = 1'($urandom_range(0, 2) != 0);
            flush = 1'($urandom_range(0, 15) == 0);
            tick();
        end
        flush = 1'b0;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
